uart_rx_ring_writer: RTL and testbench

- Parametrised successor to the UART receive-to-buffer writer.
- Takes bytes from the existing uart_rx core over its ready/ack handshake and writes them into an external dual-port RAM.
- Two modes: linear (fill once, sticky full until cleared) and ring (consumer frees slots, addresses wrap).
- Adds occupancy count, watermark flag and overflow accounting; sits between uart_rx and the RX buffer RAM read by the CPU.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_rx_ring_writer_occ_counter.sv | 43 ++++
 rtl/uart_rx_ring_writer.sv | 105 ++++++++++
 tb/tb_uart_rx_ring_writer.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive-to-RAM writer.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COMMIT   = 2'd1,
        WAIT_LOW = 2'd2
    } state_t;

    localparam int MODE_LINEAR = 0;
    localparam int MODE_RING   = 1;
    localparam int OVF_W       = 8;

endpackage

// File: rtl/uart_rx_ring_writer_occ_counter.sv
// Occupancy counter for the RX buffer: up on commit, down on release, with
// guards so it never leaves 0..DEPTH.
module occ_counter #(
    parameter int ADDR_W    = 9,
    parameter int WATERMARK = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              inc,
    input  logic              dec,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              wm
);

    localparam int               DEPTH_I = 1 << ADDR_W;
    localparam logic [ADDR_W:0]  DEPTH   = DEPTH_I[ADDR_W:0];
    localparam logic [ADDR_W:0]  WM_LVL  = WATERMARK[ADDR_W:0];

    logic do_inc;
    logic do_dec;

    assign do_inc = inc && (count != DEPTH);
    assign do_dec = dec && (count != '0);

    // A simultaneous commit and release cancel out.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (do_inc && !do_dec) begin
            count <= count + (ADDR_W+1)'(1);
        end else if (do_dec && !do_inc) begin
            count <= count - (ADDR_W+1)'(1);
        end
    end

    assign full = (count == DEPTH);
    assign wm   = (count >= WM_LVL);

endmodule

// File: rtl/uart_rx_ring_writer.sv
// Moves words from uart_rx into the RX buffer RAM, linear or ring mode,
// with occupancy, watermark and overflow accounting.
//   state    | meaning
//   IDLE     | waiting for src_ready; write or drop the word
//   COMMIT   | write strobe cycle; advance address and count
//   WAIT_LOW | wait for the source to drop src_ready
module uart_rx_ring_writer
    import uart_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 9,
    parameter int RING      = 0,
    parameter int WATERMARK = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              src_ready,
    input  logic [DATA_W-1:0] src_data,
    output logic              src_ack,
    input  logic              rd_release,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              wm,
    output logic              overflow,
    output logic [OVF_W-1:0]  overflow_cnt
);

    state_t state;
    logic   commit_inc;
    logic   release_dec;

    assign commit_inc  = (state == COMMIT) && !clear;
    assign release_dec = (RING == MODE_RING) && rd_release;

    occ_counter #(
        .ADDR_W    (ADDR_W),
        .WATERMARK (WATERMARK)
    ) u_occ (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .inc     (commit_inc),
        .dec     (release_dec),
        .count   (count),
        .full    (full),
        .wm      (wm)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            src_ack      <= 1'b0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            overflow     <= 1'b0;
            overflow_cnt <= '0;
        end else if (clear) begin
            // A word still held by the source must not be captured again.
            state        <= src_ready ? WAIT_LOW : IDLE;
            src_ack      <= 1'b0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            overflow     <= 1'b0;
            overflow_cnt <= '0;
        end else begin
            src_ack <= 1'b0;
            wr_en   <= 1'b0;
            case (state)
                IDLE: begin
                    if (src_ready) begin
                        src_ack <= 1'b1;
                        if (!full) begin
                            wr_data <= src_data;
                            wr_en   <= 1'b1;
                            state   <= COMMIT;
                        end else begin
                            overflow <= 1'b1;
                            if (overflow_cnt != '1) begin
                                overflow_cnt <= overflow_cnt + 8'd1;
                            end
                            state <= WAIT_LOW;
                        end
                    end
                end
                COMMIT: begin
                    wr_addr <= wr_addr + ADDR_W'(1);
                    state   <= WAIT_LOW;
                end
                WAIT_LOW: begin
                    if (!src_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_ring_writer.sv
// Directed bench: instance 0 is linear (DEPTH 4, WATERMARK 4),
// instance 1 is ring (DEPTH 4, WATERMARK 3).
module tb_uart_rx_ring_writer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       clear      [2];
    logic       src_ready  [2];
    logic [7:0] src_data   [2];
    logic       rd_release [2];
    logic       src_ack    [2];
    logic       wr_en      [2];
    logic [1:0] wr_addr    [2];
    logic [7:0] wr_data    [2];
    logic [2:0] count      [2];
    logic       full       [2];
    logic       wm         [2];
    logic       overflow   [2];
    logic [7:0] overflow_cnt [2];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_rx_ring_writer #(.DATA_W(8), .ADDR_W(2), .RING(0), .WATERMARK(4)) u_lin (
        .clk(clk), .reset_n(reset_n), .clear(clear[0]),
        .src_ready(src_ready[0]), .src_data(src_data[0]), .src_ack(src_ack[0]),
        .rd_release(rd_release[0]), .wr_en(wr_en[0]), .wr_addr(wr_addr[0]),
        .wr_data(wr_data[0]), .count(count[0]), .full(full[0]), .wm(wm[0]),
        .overflow(overflow[0]), .overflow_cnt(overflow_cnt[0])
    );

    uart_rx_ring_writer #(.DATA_W(8), .ADDR_W(2), .RING(1), .WATERMARK(3)) u_ring (
        .clk(clk), .reset_n(reset_n), .clear(clear[1]),
        .src_ready(src_ready[1]), .src_data(src_data[1]), .src_ack(src_ack[1]),
        .rd_release(rd_release[1]), .wr_en(wr_en[1]), .wr_addr(wr_addr[1]),
        .wr_data(wr_data[1]), .count(count[1]), .full(full[1]), .wm(wm[1]),
        .overflow(overflow[1]), .overflow_cnt(overflow_cnt[1])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr(input int i);
        clear[i] = 1'b1;
        tick();
        clear[i] = 1'b0;
    endtask

    // Source handshake: raise ready, wait for ack, drop ready, let FSM return to IDLE.
    task automatic send(input int i, input logic [7:0] d, output logic got_wr,
                        output logic [1:0] got_addr, output logic [7:0] got_data);
        bit seen;
        seen = 1'b0;
        got_wr = 1'b0; got_addr = '0; got_data = '0;
        src_data[i]  = d;
        src_ready[i] = 1'b1;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            if (src_ack[i] === 1'b1) begin
                seen     = 1'b1;
                got_wr   = wr_en[i];
                got_addr = wr_addr[i];
                got_data = wr_data[i];
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL send_ack inst=%0d data=%02h acked=0 required=1", i, d);
        end
        src_ready[i] = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            clear[i] = 1'b0; src_ready[i] = 1'b0; src_data[i] = '0; rd_release[i] = 1'b0;
        end
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({src_ack[i], wr_en[i], wr_addr[i], wr_data[i], count[i], full[i], wm[i],
                 overflow[i], overflow_cnt[i]} !== '0) begin
                failures++;
                $display("FAIL reset_outputs inst=%0d ack=%b wr_en=%b addr=%0d count=%0d ovf_cnt=%0d required all zero",
                         i, src_ack[i], wr_en[i], wr_addr[i], count[i], overflow_cnt[i]);
            end
        end
    endtask

    task automatic test_single();
        logic bad;
        src_data[0]  = 8'hA5;
        src_ready[0] = 1'b1;
        tick();
        checks++;
        if ({src_ack[0], wr_en[0], wr_addr[0], wr_data[0], count[0]} !== {2'b11, 2'd0, 8'hA5, 3'd0}) begin
            failures++;
            $display("FAIL single_write ack=%b wr_en=%b addr=%0d data=%02h count=%0d required 1 1 0 a5 0",
                     src_ack[0], wr_en[0], wr_addr[0], wr_data[0], count[0]);
        end
        tick();
        checks++;
        if ({src_ack[0], wr_en[0], wr_addr[0], count[0]} !== {2'b00, 2'd1, 3'd1}) begin
            failures++;
            $display("FAIL single_after ack=%b wr_en=%b addr=%0d count=%0d required 0 0 1 1",
                     src_ack[0], wr_en[0], wr_addr[0], count[0]);
        end
        bad = 1'b0;
        repeat (10) begin
            tick();
            if (src_ack[0] !== 1'b0 || wr_en[0] !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            failures++;
            $display("FAIL single_hold_no_reack seen=%b required=0", bad);
        end
        src_ready[0] = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_linear_fill();
        logic w; logic [1:0] a; logic [7:0] d;
        clr(0);
        for (int k = 1; k <= 4; k++) begin
            send(0, 8'(k), w, a, d);
            checks++;
            if ({w, a, d} !== {1'b1, 2'(k - 1), 8'(k)}) begin
                failures++;
                $display("FAIL linear_write_%0d wr=%b addr=%0d data=%02h required 1 %0d %02h", k, w, a, d, k - 1, k);
            end
            if (k == 3) begin
                checks++;
                if ({full[0], wm[0], count[0]} !== {2'b00, 3'd3}) begin
                    failures++;
                    $display("FAIL linear_three full=%b wm=%b count=%0d required 0 0 3", full[0], wm[0], count[0]);
                end
            end
        end
        checks++;
        if ({full[0], wm[0], count[0]} !== {2'b11, 3'd4}) begin
            failures++;
            $display("FAIL linear_full full=%b wm=%b count=%0d required 1 1 4", full[0], wm[0], count[0]);
        end
        send(0, 8'h05, w, a, d);
        checks++;
        if ({w, overflow[0], overflow_cnt[0], count[0]} !== {1'b0, 1'b1, 8'd1, 3'd4}) begin
            failures++;
            $display("FAIL linear_drop wr=%b ovf=%b ovf_cnt=%0d count=%0d required 0 1 1 4",
                     w, overflow[0], overflow_cnt[0], count[0]);
        end
        rd_release[0] = 1'b1;
        repeat (3) tick();
        rd_release[0] = 1'b0;
        tick();
        checks++;
        if ({full[0], count[0]} !== {1'b1, 3'd4}) begin
            failures++;
            $display("FAIL linear_release_ignored full=%b count=%0d required 1 4", full[0], count[0]);
        end
    endtask

    task automatic test_ring_wrap();
        logic w; logic [1:0] a; logic [7:0] d; logic anywr; logic addr_bad;
        addr_bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            send(1, 8'(8'h10 + k), w, a, d);
            if ({w, a} !== {1'b1, 2'(k)}) addr_bad = 1'b1;
        end
        checks++;
        if ({addr_bad, full[1], count[1]} !== {1'b0, 1'b1, 3'd4}) begin
            failures++;
            $display("FAIL ring_fill addr_bad=%b full=%b count=%0d required 0 1 4", addr_bad, full[1], count[1]);
        end
        rd_release[1] = 1'b1;
        tick();
        rd_release[1] = 1'b0;
        tick();
        checks++;
        if ({full[1], count[1]} !== {1'b0, 3'd3}) begin
            failures++;
            $display("FAIL ring_release full=%b count=%0d required 0 3", full[1], count[1]);
        end
        send(1, 8'h77, w, a, d);
        checks++;
        if ({w, a, d, full[1], count[1]} !== {1'b1, 2'd0, 8'h77, 1'b1, 3'd4}) begin
            failures++;
            $display("FAIL ring_wrap wr=%b addr=%0d data=%02h full=%b count=%0d required 1 0 77 1 4",
                     w, a, d, full[1], count[1]);
        end
        anywr = 1'b0;
        for (int k = 0; k < 260; k++) begin
            send(1, 8'(k), w, a, d);
            if (w !== 1'b0) anywr = 1'b1;
        end
        checks++;
        if ({anywr, overflow[1], overflow_cnt[1], count[1]} !== {1'b0, 1'b1, 8'd255, 3'd4}) begin
            failures++;
            $display("FAIL ring_ovf_saturate wr_seen=%b ovf=%b ovf_cnt=%0d count=%0d required 0 1 255 4",
                     anywr, overflow[1], overflow_cnt[1], count[1]);
        end
    endtask

    task automatic test_release_in_commit();
        logic w; logic [1:0] a; logic [7:0] d;
        clr(1);
        checks++;
        if ({overflow[1], overflow_cnt[1], count[1], wr_addr[1]} !== '0) begin
            failures++;
            $display("FAIL ring_clear ovf=%b ovf_cnt=%0d count=%0d addr=%0d required 0 0 0 0",
                     overflow[1], overflow_cnt[1], count[1], wr_addr[1]);
        end
        send(1, 8'h21, w, a, d);
        send(1, 8'h22, w, a, d);
        src_data[1]  = 8'h3C;
        src_ready[1] = 1'b1;
        tick();
        rd_release[1] = 1'b1;
        tick();
        rd_release[1] = 1'b0;
        checks++;
        if (count[1] !== 3'd2) begin
            failures++;
            $display("FAIL ring_commit_and_release count=%0d required=2", count[1]);
        end
        src_ready[1] = 1'b0;
        tick();
        tick();
        rd_release[1] = 1'b1;
        repeat (3) tick();
        rd_release[1] = 1'b0;
        tick();
        checks++;
        if ({count[1], full[1], wm[1]} !== {3'd0, 2'b00}) begin
            failures++;
            $display("FAIL ring_release_at_zero count=%0d full=%b wm=%b required 0 0 0", count[1], full[1], wm[1]);
        end
    endtask

    task automatic test_clear_in_commit();
        logic w; logic [1:0] a; logic [7:0] d; logic bad;
        clr(0);
        src_data[0]  = 8'h99;
        src_ready[0] = 1'b1;
        tick();
        clear[0] = 1'b1;
        tick();
        clear[0] = 1'b0;
        checks++;
        if ({src_ack[0], wr_en[0], count[0], wr_addr[0]} !== '0) begin
            failures++;
            $display("FAIL clear_in_commit ack=%b wr_en=%b count=%0d addr=%0d required 0 0 0 0",
                     src_ack[0], wr_en[0], count[0], wr_addr[0]);
        end
        bad = 1'b0;
        repeat (5) begin
            tick();
            if (src_ack[0] !== 1'b0 || wr_en[0] !== 1'b0 || count[0] !== 3'd0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            failures++;
            $display("FAIL clear_no_recapture seen=%b required=0", bad);
        end
        src_ready[0] = 1'b0;
        tick();
        send(0, 8'h42, w, a, d);
        checks++;
        if ({w, a, d, count[0]} !== {1'b1, 2'd0, 8'h42, 3'd1}) begin
            failures++;
            $display("FAIL clear_then_write wr=%b addr=%0d data=%02h count=%0d required 1 0 42 1", w, a, d, count[0]);
        end
    endtask

    task automatic test_watermark();
        logic w; logic [1:0] a; logic [7:0] d;
        clr(1);
        send(1, 8'h01, w, a, d);
        send(1, 8'h02, w, a, d);
        checks++;
        if ({wm[1], count[1]} !== {1'b0, 3'd2}) begin
            failures++;
            $display("FAIL wm_two wm=%b count=%0d required 0 2", wm[1], count[1]);
        end
        send(1, 8'h03, w, a, d);
        checks++;
        if ({wm[1], count[1]} !== {1'b1, 3'd3}) begin
            failures++;
            $display("FAIL wm_three wm=%b count=%0d required 1 3", wm[1], count[1]);
        end
        rd_release[1] = 1'b1;
        tick();
        rd_release[1] = 1'b0;
        tick();
        checks++;
        if ({wm[1], count[1]} !== {1'b0, 3'd2}) begin
            failures++;
            $display("FAIL wm_release wm=%b count=%0d required 0 2", wm[1], count[1]);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_linear_fill();
        test_ring_wrap();
        test_release_in_commit();
        test_clear_in_commit();
        test_watermark();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time_limit_reached checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
